// File: rtl/pin_id_scanner.sv
// ---------------------------------------------------------------------------
// pin_id_scanner
//
// Pin-identification pattern generator for board bring-up. Each output
// channel emits a repeating frame of pulse slots that encodes its package
// ball: R pulses for the row letter, a 3-slot gap, C pulses for the column
// number, then idle until the frame ends. In sequential mode only one
// channel (active_idx_o) runs per frame, which lets a probe walk the pins.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous reset, active-high
//   enable_i       run pattern generation; low forces idle and restart
//   mode_i         0 = all channels run, 1 = only active_idx_o runs
//                  (sampled at frame start only)
//   pins_o         registered pattern outputs, one bit per channel
//   active_idx_o   channel index of the current frame
//   frame_start_o  one-clock pulse on the first cycle of each frame
//   busy_o         high while a frame is in progress
// ---------------------------------------------------------------------------
module pin_id_scanner #(
    parameter int                CLK_FREQ    = 25000000,
    parameter int                TICK_HZ     = 8,
    parameter int                N_CH        = 8,
    parameter int                FRAME_SLOTS = 80,
    parameter logic [N_CH*5-1:0] ROW_ID      = '0,
    parameter logic [N_CH*5-1:0] COL_ID      = '0,
    parameter logic              IDLE_LEVEL  = 1'b0,
    localparam int               IW          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            enable_i,
    input  logic            mode_i,
    output logic [N_CH-1:0] pins_o,
    output logic [IW-1:0]   active_idx_o,
    output logic            frame_start_o,
    output logic            busy_o
);

    localparam int              DIV       = CLK_FREQ / TICK_HZ;
    localparam int              DW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST  = DW'(DIV - 1);
    localparam logic [7:0]      SLOT_LAST = 8'(FRAME_SLOTS - 1);
    localparam logic [IW-1:0]   IDX_LAST  = IW'(N_CH - 1);
    localparam logic [N_CH-1:0] ALL_IDLE  = {N_CH{IDLE_LEVEL}};

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t            state_q, state_d;
    logic              start;
    logic              tick;
    logic              wrap;
    logic [DW-1:0]     div_q;
    logic [7:0]        slot_q;
    logic [IW-1:0]     idx_q;
    logic              mode_q;
    logic              frame_start_q;
    logic [N_CH-1:0]   pins_q;
    logic [N_CH-1:0]   pattern;

    // True when slot s of a frame is a pulse slot for a channel with row
    // count r and column count c. Slots past the frame end never occur, so
    // oversized IDs are truncated for free.
    function automatic logic ch_high(input logic [7:0] s,
                                     input logic [4:0] r,
                                     input logic [4:0] c);
        logic [8:0] s9;
        logic [8:0] gap_start;
        logic [8:0] col_start;
        logic [8:0] col_end;
        s9        = {1'b0, s};
        gap_start = {3'b000, r, 1'b0};
        col_start = gap_start + 9'd3;
        col_end   = col_start + {3'b000, c, 1'b0};
        ch_high   = 1'b0;
        if (s9 < gap_start) begin
            ch_high = ~s[0];
        end else if (s9 >= col_start && s9 < col_end) begin
            // col_start = 2R+3 is odd, so (s - col_start) is even exactly
            // when s is odd.
            ch_high = s[0];
        end
    endfunction

    // ---------------------------------------------------------------------
    // Control FSM: IDLE until enable_i is seen, RUN until it drops.
    // ---------------------------------------------------------------------
    // NOTE: every signal written in this always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        if (!enable_i) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_RUN;
            start   = 1'b1;
        end
    end

    assign tick = (state_q == ST_RUN) && enable_i && (div_q == DIV_LAST);
    assign wrap = tick && (slot_q == SLOT_LAST);

    // Pattern for the current (slot, active index, latched mode); it is
    // registered, so pins_o lags those counters by one clock.
    always_comb begin
        pattern = ALL_IDLE;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_high(slot_q, ROW_ID[5*k +: 5], COL_ID[5*k +: 5]) &&
                (!mode_q || idx_q == IW'(k))) begin
                pattern[k] = ~IDLE_LEVEL;
            end
        end
    end

    // ---------------------------------------------------------------------
    // State and datapath registers.
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            div_q         <= '0;
            slot_q        <= '0;
            idx_q         <= '0;
            mode_q        <= 1'b0;
            frame_start_q <= 1'b0;
            pins_q        <= ALL_IDLE;
        end else begin
            state_q       <= state_d;
            frame_start_q <= start || wrap;

            if (!enable_i || start) begin
                // Dropping enable aborts the frame; starting clears the
                // counters so frame 0 always begins at slot 0, channel 0.
                div_q  <= '0;
                slot_q <= '0;
                idx_q  <= '0;
                if (start) begin
                    mode_q <= mode_i;
                end
            end else begin
                div_q <= tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    slot_q <= wrap ? 8'd0 : slot_q + 8'd1;
                end
                if (wrap) begin
                    idx_q  <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    mode_q <= mode_i;
                end
            end

            // The start edge still shows idle: the first real slot appears
            // one clock later, in step with the one-clock pattern latency.
            if (state_q == ST_RUN && enable_i) begin
                pins_q <= pattern;
            end else begin
                pins_q <= ALL_IDLE;
            end
        end
    end

    assign pins_o        = pins_q;
    assign active_idx_o  = idx_q;
    assign frame_start_o = frame_start_q;
    assign busy_o        = (state_q == ST_RUN);

endmodule

// File: tb/tb_pin_id_scanner.sv
// ---------------------------------------------------------------------------
// tb_pin_id_scanner
//
// Directed bring-up sequence followed by randomized enable/reset/mode
// activity. A clock-counting reference model predicts every output after
// every edge: frames are 80 clocks, slots 4 clocks, and each channel's
// pulse table is built by placing row and column pulses into an array.
// ---------------------------------------------------------------------------
module tb_pin_id_scanner;

    localparam int N_CH   = 3;
    localparam int FS     = 20;
    localparam int DIV    = 4;
    localparam int FRAME  = FS * DIV;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       enable_i = 1'b0;
    logic       mode_i = 1'b0;
    logic [2:0] pins_o;
    logic [1:0] active_idx_o;
    logic       frame_start_o;
    logic       busy_o;

    pin_id_scanner #(
        .CLK_FREQ   (16),
        .TICK_HZ    (4),
        .N_CH       (N_CH),
        .FRAME_SLOTS(FS),
        .ROW_ID     ({5'd3, 5'd2, 5'd1}),
        .COL_ID     ({5'd1, 5'd3, 5'd2}),
        .IDLE_LEVEL (1'b0)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .enable_i     (enable_i),
        .mode_i       (mode_i),
        .pins_o       (pins_o),
        .active_idx_o (active_idx_o),
        .frame_start_o(frame_start_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int   row_of [N_CH] = '{1, 2, 3};
    int   col_of [N_CH] = '{2, 3, 1};
    bit   pat [N_CH][FS];
    bit   m_run  = 1'b0;
    int   m_cyc  = 0;
    bit   m_mode = 1'b0;
    logic [2:0] e_pins = 3'b000;
    int   e_idx  = 0;
    bit   e_fs   = 1'b0;
    bit   e_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at the edge.
    task automatic model_edge();
        int prev;
        int slot_p;
        int idx_p;
        if (rst_i || !enable_i) begin
            m_run  = 1'b0;
            e_pins = 3'b000;
            e_idx  = 0;
            e_fs   = 1'b0;
            e_busy = 1'b0;
        end else if (!m_run) begin
            m_run  = 1'b1;
            m_cyc  = 0;
            m_mode = mode_i;
            e_pins = 3'b000;
            e_idx  = 0;
            e_fs   = 1'b1;
            e_busy = 1'b1;
        end else begin
            prev   = m_cyc;
            m_cyc  = m_cyc + 1;
            slot_p = (prev % FRAME) / DIV;
            idx_p  = (prev / FRAME) % N_CH;
            for (int k = 0; k < N_CH; k++)
                e_pins[k] = pat[k][slot_p] && (!m_mode || k == idx_p);
            e_fs = (m_cyc % FRAME) == 0;
            if (e_fs) m_mode = mode_i;
            e_idx  = (m_cyc / FRAME) % N_CH;
            e_busy = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check("pins", {29'd0, pins_o}, {29'd0, e_pins});
        check("active_idx", {30'd0, active_idx_o}, e_idx);
        check("frame_start", {31'd0, frame_start_o}, {31'd0, e_fs});
        check("busy", {31'd0, busy_o}, {31'd0, e_busy});
    endtask

    initial begin
        int  hi_cnt;
        int  rises;
        bit  prev0;
        bit  found;
        int  r;

        // Pulse tables: R row pulses on even slots, 3-slot gap, C column
        // pulses, clipped to the frame.
        for (int k = 0; k < N_CH; k++) begin
            for (int s = 0; s < FS; s++) pat[k][s] = 1'b0;
            for (int i = 0; i < row_of[k]; i++)
                if (2*i < FS) pat[k][2*i] = 1'b1;
            for (int j = 0; j < col_of[k]; j++)
                if (2*row_of[k] + 3 + 2*j < FS) pat[k][2*row_of[k] + 3 + 2*j] = 1'b1;
        end

        // Reset for three clocks
        rst_i = 1'b1; enable_i = 1'b0; mode_i = 1'b0;
        repeat (3) step();
        check("reset_pins", {29'd0, pins_o}, 32'd0);

        // Parallel run: first frame of channel 0 gives slots 0,5,7 -> 3
        // pulses of 4 clocks each.
        rst_i = 1'b0; enable_i = 1'b1;
        hi_cnt = 0; rises = 0; prev0 = 1'b0;
        for (int i = 0; i < 81; i++) begin
            step();
            if (pins_o[0] === 1'b1) hi_cnt++;
            if (pins_o[0] === 1'b1 && !prev0) rises++;
            prev0 = (pins_o[0] === 1'b1);
        end
        check("ch0_high_clocks", hi_cnt, 12);
        check("ch0_pulse_count", rises, 3);

        // Switch to sequential at slot 10 of the current frame
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (m_cyc % FRAME == 40) found = 1'b1;
        end
        check("reach_slot10", {31'd0, found}, 32'd1);
        mode_i = 1'b1;
        repeat (4 * FRAME) step();

        // Drop enable at slot 7 of a frame on channel 1
        found = 1'b0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            step();
            if (e_idx == 1 && (m_cyc % FRAME) / DIV == 7) found = 1'b1;
        end
        check("reach_ch1_slot7", {31'd0, found}, 32'd1);
        enable_i = 1'b0;
        step();
        check("disable_pins", {29'd0, pins_o}, 32'd0);
        check("disable_busy", {31'd0, busy_o}, 32'd0);
        repeat (4) step();
        enable_i = 1'b1;
        step();
        check("restart_fs", {31'd0, frame_start_o}, 32'd1);
        check("restart_idx", {30'd0, active_idx_o}, 32'd0);
        repeat (2 * FRAME) step();

        // Reset mid-frame with enable held high
        repeat (50) step();
        rst_i = 1'b1;
        step();
        check("midreset_busy", {31'd0, busy_o}, 32'd0);
        check("midreset_idx", {30'd0, active_idx_o}, 32'd0);
        rst_i = 1'b0;
        step();
        check("postreset_fs", {31'd0, frame_start_o}, 32'd1);
        hi_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (pins_o[0] === 1'b1) hi_cnt++;
        end
        check("postreset_ch0_high", hi_cnt, 12);

        // Randomized enable / reset / mode activity
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 399);
            rst_i = (r == 1);
            if (r == 0) enable_i = 1'b0;
            else if (r >= 2 && r <= 60) enable_i = 1'b1;
            if (r >= 390) mode_i = ~mode_i;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
